// File: rtl/task_11_stream_deserializer.sv
// Stream-to-frame deserializer: packs up to MAX_N input words into one wide output frame.
// The frame length is chosen at run time, i_last can close a frame early, and both sides use valid/ready.
module task_11_stream_deserializer #(
  parameter int MAX_N      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ORDER      = 0,
  localparam int CW        = $clog2(MAX_N + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_last,
  input  logic [CW-1:0]               i_ratio,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [MAX_N*DATA_WIDTH-1:0] o_data,
  output logic [CW-1:0]               o_count,
  output logic                        o_last
);

  logic [MAX_N*DATA_WIDTH-1:0] asm_q, asm_d, asm_new;
  logic [CW-1:0]               cnt_q, cnt_d, cnt_new;
  logic [CW-1:0]               ratio_q, ratio_d, ratio_eff, ratio_clamped;
  logic                        pend_q, pend_d;
  logic                        pend_last_q, pend_last_d;
  logic [MAX_N*DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [CW-1:0]               o_count_q, o_count_d;
  logic                        o_last_q, o_last_d;
  logic                        o_valid_q, o_valid_d;
  logic                        accept, complete, out_free;
  int                          slot_idx;

  assign i_ready = !i_rst && !pend_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_count = o_count_q;
  assign o_last  = o_last_q;

  always_comb begin
    ratio_clamped = i_ratio;
    if (i_ratio == '0 || i_ratio > CW'(MAX_N)) ratio_clamped = CW'(MAX_N);
    // Ratio is only taken from the port on the first beat; later beats use the latched value.
    ratio_eff = (cnt_q == '0) ? ratio_clamped : ratio_q;

    slot_idx = (ORDER != 0) ? (MAX_N - 1 - int'(cnt_q)) : int'(cnt_q);
    asm_new  = asm_q;
    for (int s = 0; s < MAX_N; s++) begin
      if (s == slot_idx) asm_new[s*DATA_WIDTH +: DATA_WIDTH] = i_data;
    end
    cnt_new = cnt_q + CW'(1);

    accept   = i_valid && i_ready;
    complete = accept && (cnt_new == ratio_eff || i_last);
    out_free = !o_valid_q || o_ready;

    asm_d       = asm_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    o_data_d    = o_data_q;
    o_count_d   = o_count_q;
    o_last_d    = o_last_q;
    o_valid_d   = o_valid_q;

    if (o_valid_q && o_ready) o_valid_d = 1'b0;

    if (pend_q) begin
      if (out_free) begin
        o_data_d  = asm_q;
        o_count_d = cnt_q;
        o_last_d  = pend_last_q;
        o_valid_d = 1'b1;
        asm_d     = '0;
        cnt_d     = '0;
        pend_d    = 1'b0;
      end
    end else if (complete) begin
      if (out_free) begin
        o_data_d  = asm_new;
        o_count_d = cnt_new;
        o_last_d  = i_last;
        o_valid_d = 1'b1;
        asm_d     = '0;
        cnt_d     = '0;
      end else begin
        // Output still occupied: park the finished frame and stall the input.
        asm_d       = asm_new;
        cnt_d       = cnt_new;
        pend_d      = 1'b1;
        pend_last_d = i_last;
      end
    end else if (accept) begin
      asm_d   = asm_new;
      cnt_d   = cnt_new;
      ratio_d = ratio_eff;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      ratio_q     <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      o_data_q    <= '0;
      o_count_q   <= '0;
      o_last_q    <= 1'b0;
      o_valid_q   <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      o_data_q    <= o_data_d;
      o_count_q   <= o_count_d;
      o_last_q    <= o_last_d;
      o_valid_q   <= o_valid_d;
    end
  end

endmodule
